// File: rtl/mux_ctrl_wb_if.sv
// rtl/mux_ctrl_wb_if.sv - Wishbone slave bus bundle for the mux controller
interface mux_ctrl_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mux_ctrl_wb.sv
// rtl/mux_ctrl_wb.sv - Wishbone-controlled design mux sequencer with forced reset and hold
module mux_ctrl_wb #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [7:0]  DEFAULT_HOLD = 8'd16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rstn_i,
  mux_ctrl_wb_if.slave         wb,
  output logic [3:0]           o_mux_sel,
  output logic                 o_sys_reset_enb,
  output logic                 o_auto_reset_enb,
  output logic                 o_io5_reset_enb,
  output logic [7:0]           o_design_reset,
  output logic                 o_mux_conf_clk,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_SWITCH,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t      state;
  logic [7:0]  ctrl_q;
  logic [7:0]  drst_q;
  logic [7:0]  hold_q;
  logic [7:0]  pend_q;
  logic        pend_v;
  logic [7:0]  cnt_q;
  logic        force_rst;
  logic [1:0]  rd_adr;
  logic        rd_we;

  logic        hit;
  logic        wr;
  logic [1:0]  reg_sel;
  logic [7:0]  wdat;
  logic        wr_ctrl;
  logic        start;
  logic [7:0]  start_val;
  logic [31:0] rd_val;

  wire unused_bits = ^{wb.wbs_dat_i[31:8], wb.wbs_adr_i[1:0]};

  assign hit       = wb.wbs_stb_i & wb.wbs_cyc_i &
                     (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wb.wbs_ack_o;
  assign wr        = hit & wb.wbs_we_i;
  assign reg_sel   = wb.wbs_adr_i[3:2];
  assign wdat      = wb.wbs_dat_i[7:0];
  assign wr_ctrl   = wr & (reg_sel == 2'd0);
  // A fresh write in IDLE supersedes anything left pending
  assign start     = wr_ctrl | pend_v;
  assign start_val = wr_ctrl ? wdat : pend_q;

  assign o_design_reset = force_rst ? 8'hFF : drst_q;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state            <= S_IDLE;
      ctrl_q           <= 8'h00;
      drst_q           <= 8'hFF;
      hold_q           <= DEFAULT_HOLD;
      pend_q           <= 8'h00;
      pend_v           <= 1'b0;
      cnt_q            <= 8'h00;
      force_rst        <= 1'b0;
      rd_adr           <= 2'd0;
      rd_we            <= 1'b0;
      wb.wbs_ack_o     <= 1'b0;
      o_mux_sel        <= 4'h0;
      o_sys_reset_enb  <= 1'b0;
      o_auto_reset_enb <= 1'b0;
      o_io5_reset_enb  <= 1'b0;
      o_mux_conf_clk   <= 1'b0;
      o_busy           <= 1'b0;
    end else begin
      wb.wbs_ack_o <= hit;
      if (hit) begin
        rd_adr <= reg_sel;
        rd_we  <= wb.wbs_we_i;
      end
      if (wr && reg_sel == 2'd1) drst_q <= wdat;
      if (wr && reg_sel == 2'd2) hold_q <= wdat;
      if (state != S_IDLE && wr_ctrl) begin
        pend_q <= wdat;
        pend_v <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            ctrl_q <= start_val;
            pend_v <= 1'b0;
            o_busy <= 1'b1;
            if (start_val[7]) begin
              state     <= S_ASSERT;
              force_rst <= 1'b1;
            end else begin
              // Direct update: no forced reset, just relatch the mux
              state            <= S_PULSE;
              o_mux_sel        <= start_val[3:0];
              o_sys_reset_enb  <= start_val[4];
              o_auto_reset_enb <= start_val[5];
              o_io5_reset_enb  <= start_val[6];
              o_mux_conf_clk   <= 1'b1;
            end
          end
        end
        S_ASSERT: begin
          state            <= S_SWITCH;
          o_mux_sel        <= ctrl_q[3:0];
          o_sys_reset_enb  <= ctrl_q[4];
          o_auto_reset_enb <= ctrl_q[5];
          o_io5_reset_enb  <= ctrl_q[6];
        end
        S_SWITCH: begin
          state          <= S_PULSE;
          o_mux_conf_clk <= 1'b1;
        end
        S_PULSE: begin
          o_mux_conf_clk <= 1'b0;
          if (ctrl_q[7]) begin
            state <= S_HOLD;
            cnt_q <= hold_q;
          end else begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        S_HOLD: begin
          // A zero count behaves like one so HOLD always lasts at least a cycle
          if (cnt_q <= 8'd1) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            force_rst <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = 32'h0;
    if (wb.wbs_ack_o && !rd_we) begin
      case (rd_adr)
        2'd0: rd_val = {24'h0, ctrl_q};
        2'd1: rd_val = {24'h0, drst_q};
        2'd2: rd_val = {24'h0, hold_q};
        2'd3: rd_val = {23'h0, o_busy, pend_v, 3'b000, o_mux_sel};
      endcase
    end
  end

  assign wb.wbs_dat_o = rd_val;

endmodule

// File: doc/mux_ctrl_wb.md
MUX_CTRL_WB -- requirements
Module: mux_ctrl_wb

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; only adr[31:4] is compared.
REQ-002 SHALL have parameter DEFAULT_HOLD, default 8'd16, reset value of the HOLD register.
REQ-003 SHALL have wb_clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have wb_rstn_i  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
REQ-006 SHALL have wbs_adr_i  in  32 and wbs_dat_i  in  32  Wishbone address and write data.
REQ-007 SHALL have wbs_ack_o  out  1 and wbs_dat_o  out  32  Wishbone acknowledge and read data.
REQ-008 SHALL have o_mux_sel  out  4  design select driven to the mux.
REQ-009 SHALL have o_sys_reset_enb, o_auto_reset_enb, o_io5_reset_enb  out  1 each  mux control bits.
REQ-010 SHALL have o_design_reset  out  8  per-design reset driven to the mux.
REQ-011 SHALL have o_mux_conf_clk  out  1  one-cycle strobe that latches the mux configuration.
REQ-012 SHALL have o_busy  out  1  high whenever the sequencer is not in IDLE.

Function
REQ-013 Hit SHALL be stb & cyc & (adr[31:4]==BASE_ADDR[31:4]) & !ack; ack SHALL be high for exactly the one cycle after a hit; misses SHALL never ack.
REQ-014 Register map on adr[3:2]: 0 CTRL {[7]seq_en,[6]io5_enb,[5]auto_enb,[4]sys_enb,[3:0]sel}; 1 DRST[7:0]; 2 HOLD[7:0]; 3 STATUS (RO) {[8]busy,[7:4]pending_valid+3'b0,[3:0]o_mux_sel}.
REQ-015 Reads SHALL return the register value in the ack cycle, with unused bits 0; wbs_dat_o SHALL be 0 outside ack cycles; writes to STATUS SHALL be ignored but still acked.
REQ-016 Sequencer states SHALL be IDLE, ASSERT, SWITCH, PULSE, HOLD.
REQ-017 A CTRL write in IDLE with seq_en=1 SHALL move to ASSERT on the edge that raises ack.
REQ-018 ASSERT->SWITCH->PULSE->HOLD SHALL each take one cycle. o_mux_sel and enb outputs SHALL take the new values on entry to SWITCH. o_mux_conf_clk SHALL be 1 only during PULSE.
REQ-019 HOLD SHALL load a down-counter with HOLD on entry, stay until the counter reaches 0, then go to IDLE; HOLD=0 SHALL give a one-cycle HOLD.
REQ-020 In ASSERT, SWITCH, PULSE and HOLD, o_design_reset SHALL be 8'hFF; in IDLE it SHALL equal DRST.
REQ-021 A CTRL write in IDLE with seq_en=0 SHALL update the outputs on the edge that raises ack and go to PULSE then IDLE, skipping ASSERT, SWITCH and HOLD; no forced reset.
REQ-022 A CTRL write while busy SHALL be stored in a one-deep pending register, last write wins, and set pending_valid. On return to IDLE it SHALL start one cycle later as if freshly written, clearing pending_valid.
REQ-023 DRST and HOLD writes SHALL take effect on the next edge in any state. A HOLD write during HOLD SHALL NOT reload the active counter.

Reset
REQ-024 While wb_rstn_i=0, the following SHALL hold asynchronously:
- o_mux_sel=0, all enb outputs=0, o_design_reset=8'hFF, o_mux_conf_clk=0, o_busy=0.
- wbs_ack_o=0, wbs_dat_o=0.
- CTRL=0, DRST=8'hFF, HOLD=DEFAULT_HOLD, pending cleared, state IDLE.
REQ-025 Reset mid-sequence SHALL abort to IDLE with the reset values; no o_mux_conf_clk pulse SHALL be emitted after reset asserts.

Verification
REQ-026 Release reset, write CTRL=0x83 with HOLD=4 -> o_design_reset=FF for 7 cycles (ASSERT, SWITCH, PULSE, 4 HOLD); o_mux_sel=3 from SWITCH; single conf_clk pulse; then o_design_reset=DRST=FF.
REQ-027 Write DRST=0xF7, then CTRL=0x03 -> o_mux_sel=3 the cycle after ack, one conf_clk pulse, o_design_reset stays 0xF7, o_busy high for one cycle only.
REQ-028 During HOLD, write CTRL=0x85 then 0x86 -> STATUS pending bit set; after IDLE exactly one new sequence runs with sel=6; sel=5 never appears.
REQ-029 Read STATUS mid-sequence -> bit8=1, [3:0]=new sel. Access to adr 0x3000_0010 -> no ack, no register change.
REQ-030 Assert wb_rstn_i low during PULSE -> outputs immediately take the REQ-024 values, conf_clk drops, HOLD reads back DEFAULT_HOLD.
